// File: rtl/decode_stage_pipelined.sv
// Decode stage: main decoder, register file with write-first bypass, immediate generation,
// multi-cycle load-use stall and the registered ID/EX pipeline register.
module decode_stage_pipelined #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [31:0]     id_instr_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            pc_en_o,
  output logic            ifid_en_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [3:0]      ex_alu_ctl_o,
  output logic [8:0]      ex_ctrl_o
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // ex_ctrl bit positions: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUop}
  localparam int unsigned CtrlMemRead = 5;

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1_idx, rs2_idx, wb_idx, ex_rd_idx;
  logic [8:0]      ctrl_dec;
  logic [XLEN-1:0] imm_dec;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic            hazard, stall;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [1:0]      cnt_q, cnt_d;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [4:0]      ex_rs1_q, ex_rs1_d;
  logic [4:0]      ex_rs2_q, ex_rs2_d;
  logic [3:0]      ex_alu_ctl_q, ex_alu_ctl_d;
  logic [8:0]      ex_ctrl_q, ex_ctrl_d;

  assign opcode    = id_instr_i[6:0];
  assign rs1_idx   = id_instr_i[15 +: RW];
  assign rs2_idx   = id_instr_i[20 +: RW];
  assign wb_idx    = wb_rd_i[RW-1:0];
  assign ex_rd_idx = ex_rd_q[RW-1:0];

  always_comb begin
    ctrl_dec = 9'b0;
    unique case (opcode)
      OpR:      ctrl_dec = 9'b001000010;
      OpIAlu:   ctrl_dec = 9'b101000010;
      OpLoad:   ctrl_dec = 9'b111100000;
      OpStore:  ctrl_dec = 9'b100010000;
      OpBranch: ctrl_dec = 9'b000001001;
      OpJal:    ctrl_dec = 9'b001000100;
      default:  ctrl_dec = 9'b0;
    endcase
  end

  always_comb begin
    imm_dec = '0;
    unique case (opcode)
      OpIAlu, OpLoad: imm_dec = {{(XLEN-12){id_instr_i[31]}}, id_instr_i[31:20]};
      OpStore:        imm_dec = {{(XLEN-12){id_instr_i[31]}}, id_instr_i[31:25],
                                 id_instr_i[11:7]};
      OpBranch:       imm_dec = {{(XLEN-13){id_instr_i[31]}}, id_instr_i[31], id_instr_i[7],
                                 id_instr_i[30:25], id_instr_i[11:8], 1'b0};
      OpJal:          imm_dec = {{(XLEN-21){id_instr_i[31]}}, id_instr_i[31],
                                 id_instr_i[19:12], id_instr_i[20], id_instr_i[30:21], 1'b0};
      default:        imm_dec = '0;
    endcase
  end

  // Write-first: a same-cycle writeback to the source register wins over the array.
  always_comb begin
    if (rs1_idx == '0) begin
      rs1_rd = '0;
    end else if (wb_we_i && (wb_idx == rs1_idx)) begin
      rs1_rd = wb_data_i;
    end else begin
      rs1_rd = regs_q[rs1_idx];
    end
    if (rs2_idx == '0) begin
      rs2_rd = '0;
    end else if (wb_we_i && (wb_idx == rs2_idx)) begin
      rs2_rd = wb_data_i;
    end else begin
      rs2_rd = regs_q[rs2_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we_i && (wb_idx != '0)) begin
      regs_q[wb_idx] <= wb_data_i;
    end
  end

  assign hazard = id_valid_i & ex_valid_q & ex_ctrl_q[CtrlMemRead] & (ex_rd_idx != '0) &
                  ((ex_rd_idx == rs1_idx) | (ex_rd_idx == rs2_idx));
  assign stall  = hazard | (cnt_q != 2'd0);

  assign pc_en_o   = ~stall | flush_i;
  assign ifid_en_o = ~stall | flush_i;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end else if (hazard) begin
      cnt_d = 2'(LOAD_STALL - 1);
    end
  end

  // Flush and stall both insert a bubble; only a normal cycle captures the decoded fields.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_alu_ctl_d  = ex_alu_ctl_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (flush_i || stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 9'b0;
    end else begin
      ex_valid_d    = id_valid_i;
      ex_pc_d       = id_pc_i;
      ex_rs1_data_d = rs1_rd;
      ex_rs2_data_d = rs2_rd;
      ex_imm_d      = imm_dec;
      ex_rd_d       = id_instr_i[11:7];
      ex_rs1_d      = id_instr_i[19:15];
      ex_rs2_d      = id_instr_i[24:20];
      ex_alu_ctl_d  = {id_instr_i[30], id_instr_i[14:12]};
      ex_ctrl_d     = id_valid_i ? ctrl_dec : 9'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= 2'd0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= 5'd0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_alu_ctl_q  <= 4'd0;
      ex_ctrl_q     <= 9'd0;
    end else begin
      cnt_q         <= cnt_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_alu_ctl_q  <= ex_alu_ctl_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_rs1_data_o = ex_rs1_data_q;
  assign ex_rs2_data_o = ex_rs2_data_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_rs1_o      = ex_rs1_q;
  assign ex_rs2_o      = ex_rs2_q;
  assign ex_alu_ctl_o  = ex_alu_ctl_q;
  assign ex_ctrl_o     = ex_ctrl_q;

endmodule
